// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and serial sequencer state encoding
//
// Purpose: op-code constants and sequencer state type used by the serial
//          ALU, the parallel ALU and their benches.
// Contents: OP_ADD/OP_SUB/OP_AND/OP_OR/OP_XOR, alu_state_e, is_arith().
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   // ADD and SUB are the only ops that propagate a carry/borrow.
   function automatic logic is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_1bit.sv
// rtl/alu_1bit.sv - single-bit ALU slice with carry/borrow in and out
//
// Purpose: combinational one-bit ALU step.
// Ports:
//   a_i, b_i   operand bits
//   cin_i      carry in (ADD) or borrow in (SUB)
//   op_i       3-bit op code from alu_pkg
//   res_o      result bit
//   cout_o     carry out (ADD) or borrow out (SUB); 0 for other ops
// Reserved op codes produce res_o=0, cout_o=0.
module alu_1bit
   import alu_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       cin_i,
   input  logic [2:0] op_i,
   output logic       res_o,
   output logic       cout_o
);

   always_comb begin
      res_o  = 1'b0;
      cout_o = 1'b0;
      case (op_i)
         OP_ADD: begin
            res_o  = a_i ^ b_i ^ cin_i;
            cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
         end
         OP_SUB: begin
            res_o  = a_i ^ b_i ^ cin_i;
            // Borrow when subtrahend plus incoming borrow exceeds a_i.
            cout_o = (~a_i & b_i) | (cin_i & ~(a_i ^ b_i));
         end
         OP_AND:  res_o = a_i & b_i;
         OP_OR:   res_o = a_i | b_i;
         OP_XOR:  res_o = a_i ^ b_i;
         default: res_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial ALU sequencer around one alu_1bit slice
//
// Purpose: accepts an operand pair and op over a valid/ready handshake,
//          computes LSB-first one bit per clock, returns result and flags
//          over a second valid/ready handshake.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    request handshake; in_a, in_b, in_op request payload
//   out_valid/out_ready  response handshake
//   out_result           assembled result
//   out_cout             ADD carry-out / SUB borrow-out, 0 otherwise
//   out_zero             out_result == 0
//   busy                 sequencer not idle
//   out_ovf              signed overflow for ADD/SUB (only with ALU_SERIAL_OVF_EN)
// Optional feature macro: ALU_SERIAL_OVF_EN
module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_zero,
   output logic             busy
`ifdef ALU_SERIAL_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   alu_state_e       state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [2:0]       op_q,     op_d;
   logic             carry_q,  carry_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q,   cout_d;
   logic             zero_q,   zero_d;
`ifdef ALU_SERIAL_OVF_EN
   logic             ovf_q,    ovf_d;
`endif

   logic             slice_res;
   logic             slice_cout;
   logic [WIDTH-1:0] res_next;

   alu_1bit u_slice (
      .a_i    (a_sh_q[0]),
      .b_i    (b_sh_q[0]),
      .cin_i  (carry_q),
      .op_i   (op_q),
      .res_o  (slice_res),
      .cout_o (slice_cout)
   );

   // Result bits enter at the MSB so the LSB-first stream lands in place
   // after exactly WIDTH shifts.
   assign res_next = {slice_res, res_sh_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         op_q     <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         zero_q   <= zero_d;
`ifdef ALU_SERIAL_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      op_d     = op_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cout_d   = cout_q;
      zero_d   = zero_q;
`ifdef ALU_SERIAL_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = in_a;
               b_sh_d  = in_b;
               op_d    = in_op;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_sh_d = res_next;
            carry_d  = slice_cout;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d  = DONE;
               result_d = res_next;
               cout_d   = slice_cout;
               zero_d   = (res_next == '0);
`ifdef ALU_SERIAL_OVF_EN
               // carry_q here is the carry into the MSB step.
               ovf_d    = is_arith(op_q) & (carry_q ^ slice_cout);
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign out_result = result_q;
   assign out_cout   = cout_q;
   assign out_zero   = zero_q;
`ifdef ALU_SERIAL_OVF_EN
   assign out_ovf    = ovf_q;
`endif

endmodule
